calc_sequencer: RTL and testbench
=================================

CALC_SEQUENCER -- requirements
Module: calc_sequencer

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, command queue depth; legal values 2, 4, 8.
REQ-002 clk  in  1  single clock; all state updates on posedge.
REQ-003 rst_n  in  1  asynchronous, active-low reset.
REQ-004 cmd_valid  in  1  command offered.
REQ-005 cmd_ready  out  1  queue can accept a command.
REQ-006 cmd_op  in  3  ALU control code: 000 AND, 001 OR, 010 ADD, 100 AND-NOT, 101 OR-NOT, 110 SUB, 111 SLT; 011 illegal.
REQ-007 cmd_src  in  2  source register (operand A).
REQ-008 cmd_dst  in  2  destination register.
REQ-009 cmd_imm  in  4  immediate (operand B).
REQ-010 cmd_wb  in  1  1 = write the result to cmd_dst.
REQ-011 rf_rd_addr  out  2 / rf_rd_data  in  4  register file read port; read is combinational.
REQ-012 rf_wr_en  out  1 / rf_wr_addr  out  2 / rf_wr_data  out  4  register file write port.
REQ-013 alu_a  out  4 / alu_b  out  4 / alu_control  out  3 / alu_res  in  4 / alu_carry  in  1  ALU port; ALU is combinational.
REQ-014 rsp_valid  out  1 / rsp_ready  in  1 / rsp_data  out  4 / rsp_carry  out  1 / rsp_err  out  1  result response.
REQ-015 busy  out  1  high when the FSM is not in IDLE or the queue is non-empty.

Function
REQ-016 A command SHALL be pushed on each posedge with cmd_valid && cmd_ready; cmd_ready = queue not full, with no bypass of a full queue.
REQ-017 Queue SHALL be FIFO-ordered; pointers wrap modulo FIFO_DEPTH; push and pop in the same cycle SHALL be legal when the queue is neither empty nor full, and the count SHALL stay unchanged.
REQ-018 FSM states SHALL be IDLE, READ, EXEC, WRITE, RESP.
REQ-019 IDLE: if the queue is non-empty, pop the head into the working register and go to READ; otherwise stay.
REQ-020 READ: drive rf_rd_addr = src; capture rf_rd_data into the operand register at the clock edge; go to EXEC.
REQ-021 EXEC: drive alu_a = operand, alu_b = imm, alu_control = op; capture alu_res/alu_carry at the clock edge; go to WRITE.
REQ-022 WRITE: assert rf_wr_en for exactly one cycle with rf_wr_addr = dst and rf_wr_data = captured result, only if wb = 1 and the command is not rejected; go to RESP.
REQ-023 RESP: hold rsp_valid = 1 and stable rsp_data/rsp_carry/rsp_err until rsp_valid && rsp_ready; then go to IDLE.
REQ-024 Latency: rsp_valid SHALL rise 4 cycles after the push edge of a command entering an empty queue with an idle FSM; sustained throughput SHALL be 1 command per 5 cycles when rsp_ready = 1.
REQ-025 rsp_carry SHALL forward alu_carry unmodified, so it is 0 for operations other than ADD/SUB.
REQ-026 When not in READ/EXEC, rf_rd_addr, alu_a, alu_b and alu_control SHALL be 0; rf_wr_addr and rf_wr_data SHALL be 0 when rf_wr_en = 0.
REQ-027 A command that writes Rn followed by one that reads Rn SHALL see the new value, because the write completes before the next READ.

Reset
REQ-028 On rst_n low: FSM to IDLE, queue emptied, in-flight command dropped without a write, and all outputs 0 except cmd_ready = 1.
REQ-029 Reset assertion during WRITE SHALL deassert rf_wr_en immediately, asynchronously.

Configuration
REQ-030 Macro CALC_SEQ_ERR_CHECK_EN defined: op 011 SHALL skip the write and return rsp_err = 1, rsp_data = 0, rsp_carry = 0.
REQ-031 Macro CALC_SEQ_ERR_CHECK_EN undefined: rsp_err SHALL be tied to 0, and op 011 SHALL be passed to the ALU and handled like any other operation.

Verification
REQ-032 Reset, then cmd {op=010, src=0, imm=5, dst=1, wb=1} with R0 = 0 -> rf_wr_en one cycle, addr 1, data 5; rsp_data = 5; rsp_valid 4 cycles after push.
REQ-033 R1 = 3, cmd {op=110, src=1, imm=5, wb=1, dst=2} then cmd {op=111, src=1, imm=5, wb=0} -> rsp_data 4'hE (carry 0), then 4'h1 with no write.
REQ-034 rsp_ready held 0, FIFO_DEPTH + 2 commands offered -> cmd_ready drops after the queue fills; after releasing rsp_ready, all responses arrive in order.
REQ-035 rst_n pulsed low during WRITE of a wb = 1 command -> rf_wr_en falls at once, queue empty, no response.
REQ-036 op = 011 with CALC_SEQ_ERR_CHECK_EN defined -> rsp_err = 1, no write; with the macro undefined -> rsp_err = 0, and ALU output is returned and written when wb = 1.

Source files
------------

// File: rtl/calc_sequencer_if.sv
// ---------------------------------------------------------------------------
// calc_sequencer_if
// Command and response handshake bundle for calc_sequencer.
//   cmd_valid/cmd_ready : command offer / queue can accept
//   cmd_op/src/dst/imm/wb : command fields (ALU code, source reg, dest reg,
//                           immediate operand B, write-back enable)
//   rsp_valid/rsp_ready : result offer / consumer accepts
//   rsp_data/carry/err  : result fields
// Modports: master = command producer / response consumer,
//           slave  = the sequencer.
// ---------------------------------------------------------------------------
interface calc_sequencer_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [2:0] cmd_op;
    logic [1:0] cmd_src;
    logic [1:0] cmd_dst;
    logic [3:0] cmd_imm;
    logic       cmd_wb;

    logic       rsp_valid;
    logic       rsp_ready;
    logic [3:0] rsp_data;
    logic       rsp_carry;
    logic       rsp_err;

    modport master (
        output cmd_valid, cmd_op, cmd_src, cmd_dst, cmd_imm, cmd_wb,
        input  cmd_ready,
        input  rsp_valid, rsp_data, rsp_carry, rsp_err,
        output rsp_ready
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_src, cmd_dst, cmd_imm, cmd_wb,
        output cmd_ready,
        output rsp_valid, rsp_data, rsp_carry, rsp_err,
        input  rsp_ready
    );
endinterface

// File: rtl/calc_sequencer.sv
// ---------------------------------------------------------------------------
// calc_sequencer
// Queues commands and runs each one through an external register file and
// an external combinational ALU: read source register, execute with the
// immediate, optionally write the result back, then hand out a response.
//
// Ports:
//   clk, rst_n      : single clock, asynchronous active-low reset
//   bus (slave)     : command queue input and response output handshakes
//   rf_rd_addr/data : combinational register file read port
//   rf_wr_en/addr/data : register file write port (one cycle per write)
//   alu_a/b/control, alu_res/carry : combinational ALU port
//   busy            : FSM not idle or queue non-empty
//
// Parameter FIFO_DEPTH: command queue depth, legal values 2, 4, 8.
//
// Build option: define CALC_SEQ_ERR_CHECK_EN to reject op 3'b011; a rejected
// command skips its write and responds with rsp_err = 1, data 0, carry 0.
// Without it rsp_err is always 0 and op 3'b011 goes to the ALU as usual.
//
// FSM states:
//   state | meaning
//   IDLE  | wait for a queued command, pop head into working register
//   READ  | drive rf_rd_addr = src, capture operand A
//   EXEC  | drive ALU with operand / imm / op, capture result and carry
//   WRITE | one-cycle register file write when wb = 1 and not rejected
//   RESP  | hold response until rsp_ready
// ---------------------------------------------------------------------------
module calc_sequencer #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    calc_sequencer_if.slave bus,
    output logic [1:0]      rf_rd_addr,
    input  logic [3:0]      rf_rd_data,
    output logic            rf_wr_en,
    output logic [1:0]      rf_wr_addr,
    output logic [3:0]      rf_wr_data,
    output logic [3:0]      alu_a,
    output logic [3:0]      alu_b,
    output logic [2:0]      alu_control,
    input  logic [3:0]      alu_res,
    input  logic            alu_carry,
    output logic            busy
);

    localparam int              PW        = $clog2(FIFO_DEPTH);
    localparam logic [PW:0]     DEPTH_CNT = (PW + 1)'(FIFO_DEPTH);
    localparam logic [PW-1:0]   LAST_PTR  = PW'(FIFO_DEPTH - 1);

    typedef struct packed {
        logic [2:0] op;
        logic [1:0] src;
        logic [1:0] dst;
        logic [3:0] imm;
        logic       wb;
    } cmd_t;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        READ  = 3'd1,
        EXEC  = 3'd2,
        WRITE = 3'd3,
        RESP  = 3'd4
    } state_t;

    // -----------------------------------------------------------------------
    // Command queue
    // -----------------------------------------------------------------------
    cmd_t          fifo_mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW:0]   count;
    logic          full;
    logic          empty;
    logic          push;
    logic          pop;
    cmd_t          cmd_in;

    state_t        state;
    state_t        state_n;
    cmd_t          cur;
    logic [3:0]    operand;
    logic [3:0]    result;
    logic          carry_q;
    logic          err_q;
    logic          illegal;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    assign cmd_in = {bus.cmd_op, bus.cmd_src, bus.cmd_dst, bus.cmd_imm, bus.cmd_wb};

    assign full          = (count == DEPTH_CNT);
    assign empty         = (count == '0);
    assign bus.cmd_ready = ~full;
    // No bypass: a command always lands in the queue before the FSM sees it.
    assign push          = bus.cmd_valid & ~full;

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= cmd_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Illegal-op detection (build option)
    // -----------------------------------------------------------------------
`ifdef CALC_SEQ_ERR_CHECK_EN
    assign illegal = (cur.op == 3'b011);
`else
    assign illegal = 1'b0;
`endif

    // -----------------------------------------------------------------------
    // FSM
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // All outputs are decoded from the registered state, so an asynchronous
    // reset during WRITE drops rf_wr_en without waiting for a clock edge.
    always_comb begin
        state_n       = state;
        pop           = 1'b0;
        rf_rd_addr    = '0;
        alu_a         = '0;
        alu_b         = '0;
        alu_control   = '0;
        rf_wr_en      = 1'b0;
        rf_wr_addr    = '0;
        rf_wr_data    = '0;
        bus.rsp_valid = 1'b0;
        bus.rsp_data  = '0;
        bus.rsp_carry = 1'b0;
        bus.rsp_err   = 1'b0;

        case (state)
            IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    state_n = READ;
                end
            end
            READ: begin
                rf_rd_addr = cur.src;
                state_n    = EXEC;
            end
            EXEC: begin
                alu_a       = operand;
                alu_b       = cur.imm;
                alu_control = cur.op;
                state_n     = WRITE;
            end
            WRITE: begin
                if (cur.wb && !err_q) begin
                    rf_wr_en   = 1'b1;
                    rf_wr_addr = cur.dst;
                    rf_wr_data = result;
                end
                state_n = RESP;
            end
            RESP: begin
                bus.rsp_valid = 1'b1;
                bus.rsp_data  = result;
                bus.rsp_carry = carry_q;
                bus.rsp_err   = err_q;
                if (bus.rsp_ready) begin
                    state_n = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Working register and captured operand / result
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur     <= '0;
            operand <= '0;
            result  <= '0;
            carry_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            if (pop) begin
                cur <= fifo_mem[rd_ptr];
            end
            if (state == READ) begin
                operand <= rf_rd_data;
            end
            if (state == EXEC) begin
                result  <= illegal ? 4'h0 : alu_res;
                carry_q <= illegal ? 1'b0 : alu_carry;
                err_q   <= illegal;
            end
        end
    end

    assign busy = (state != IDLE) || !empty;

endmodule

// File: tb/tb_calc_sequencer.sv
// ---------------------------------------------------------------------------
// tb_calc_sequencer
// Drives calc_sequencer with directed and random commands. The bench owns a
// register file and an ALU model wired to the DUT, and keeps a reference
// model that executes commands in order on its own register copy to predict
// responses and register writes.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_calc_sequencer;
    localparam int FIFO_DEPTH = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    calc_sequencer_if bus();

    logic [1:0] rf_rd_addr;
    logic [3:0] rf_rd_data;
    logic       rf_wr_en;
    logic [1:0] rf_wr_addr;
    logic [3:0] rf_wr_data;
    logic [3:0] alu_a;
    logic [3:0] alu_b;
    logic [2:0] alu_control;
    logic [3:0] alu_res;
    logic       alu_carry;
    logic       busy;

    calc_sequencer #(.FIFO_DEPTH(FIFO_DEPTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .rf_rd_addr (rf_rd_addr),
        .rf_rd_data (rf_rd_data),
        .rf_wr_en   (rf_wr_en),
        .rf_wr_addr (rf_wr_addr),
        .rf_wr_data (rf_wr_data),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_control(alu_control),
        .alu_res    (alu_res),
        .alu_carry  (alu_carry),
        .busy       (busy)
    );

    // ALU: returns {carry, result}. SUB carry is the carry out of a + ~b + 1.
    function automatic logic [4:0] alu_fn(input logic [2:0] op, input logic [3:0] a,
                                          input logic [3:0] b);
        case (op)
            3'b000:  return {1'b0, a & b};
            3'b001:  return {1'b0, a | b};
            3'b010:  return {1'b0, a} + {1'b0, b};
            3'b100:  return {1'b0, a & ~b};
            3'b101:  return {1'b0, a | ~b};
            3'b110:  return {1'b0, a} + {1'b0, ~b} + 5'd1;
            3'b111:  return ($signed(a) < $signed(b)) ? 5'd1 : 5'd0;
            default: return {1'b0, a ^ b};
        endcase
    endfunction

    assign {alu_carry, alu_res} = alu_fn(alu_control, alu_a, alu_b);

    // External register file with a bench-side poke port.
    logic [3:0] rf [4];
    logic       poke_en = 1'b0;
    logic [1:0] poke_addr = 2'd0;
    logic [3:0] poke_data = 4'd0;
    assign rf_rd_data = rf[rf_rd_addr];
    always @(posedge clk) begin
        if (poke_en) rf[poke_addr] <= poke_data;
        else if (rf_wr_en) rf[rf_wr_addr] <= rf_wr_data;
    end

    typedef struct packed { logic [3:0] data; logic carry; logic err; } rsp_t;
    typedef struct packed { logic [1:0] addr; logic [3:0] data; } wr_t;

    rsp_t exp_rsp[$];
    rsp_t obs_rsp[$];
    wr_t  exp_wr[$];
    wr_t  obs_wr[$];
    int   hs_cyc[$];
    logic [3:0] mdl_rf [4];

    int n_checks = 0;
    int n_fail = 0;
    int push_timeouts = 0;
    int drain_timeouts = 0;
    int viol = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Observer: records handshakes and writes, counts protocol violations.
    bit   prev_stall = 0;
    bit   prev_wr = 0;
    rsp_t prev_rsp;
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 0;
            prev_wr = 0;
        end else begin
            if (prev_stall && (!bus.rsp_valid ||
                {bus.rsp_data, bus.rsp_carry, bus.rsp_err} != prev_rsp)) viol++;
            if (bus.rsp_valid && bus.rsp_ready) begin
                obs_rsp.push_back({bus.rsp_data, bus.rsp_carry, bus.rsp_err});
                hs_cyc.push_back(cyc);
            end
            prev_stall = bus.rsp_valid && !bus.rsp_ready;
            prev_rsp = {bus.rsp_data, bus.rsp_carry, bus.rsp_err};
            if (rf_wr_en) begin
                obs_wr.push_back({rf_wr_addr, rf_wr_data});
                if (prev_wr) viol++;
            end else if (rf_wr_addr != 2'd0 || rf_wr_data != 4'd0) begin
                viol++;
            end
            prev_wr = rf_wr_en;
            if (!busy && (rf_rd_addr != 2'd0 || alu_a != 4'd0 || alu_b != 4'd0 ||
                          alu_control != 3'd0 || bus.rsp_valid)) viol++;
        end
    end

    // Reference model: commands execute strictly in order on mdl_rf.
    task automatic model_cmd(input logic [2:0] op, input logic [1:0] src, input logic [1:0] dst,
                             input logic [3:0] imm, input logic wb);
        logic [4:0] r;
        r = alu_fn(op, mdl_rf[src], imm);
`ifdef CALC_SEQ_ERR_CHECK_EN
        if (op == 3'b011) begin
            exp_rsp.push_back({4'h0, 1'b0, 1'b1});
            return;
        end
`endif
        exp_rsp.push_back({r[3:0], r[4], 1'b0});
        if (wb) begin
            mdl_rf[dst] = r[3:0];
            exp_wr.push_back({dst, r[3:0]});
        end
    endtask

    task automatic push_cmd(input logic [2:0] op, input logic [1:0] src, input logic [1:0] dst,
                            input logic [3:0] imm, input logic wb, input bit track);
        bit done;
        done = 0;
        @(negedge clk);
        bus.cmd_valid = 1'b1;
        bus.cmd_op = op;
        bus.cmd_src = src;
        bus.cmd_dst = dst;
        bus.cmd_imm = imm;
        bus.cmd_wb = wb;
        for (int i = 0; i < 500 && !done; i++) begin
            if (bus.cmd_ready) begin
                @(posedge clk);
                done = 1;
            end else begin
                @(negedge clk);
            end
        end
        #1;
        bus.cmd_valid = 1'b0;
        if (!done) push_timeouts++;
        else if (track) model_cmd(op, src, dst, imm, wb);
    endtask

    task automatic push_random();
        push_cmd(3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 1'b1);
    endtask

    task automatic rf_poke(input logic [1:0] a, input logic [3:0] d);
        @(negedge clk);
        poke_en = 1'b1;
        poke_addr = a;
        poke_data = d;
        @(negedge clk);
        poke_en = 1'b0;
        mdl_rf[a] = d;
    endtask

    task automatic drain();
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (!busy && obs_rsp.size() >= exp_rsp.size()) return;
        end
        drain_timeouts++;
    endtask

    task automatic test_reset();
        bus.cmd_valid = 1'b0;
        bus.cmd_op = 3'd0;
        bus.cmd_src = 2'd0;
        bus.cmd_dst = 2'd0;
        bus.cmd_imm = 4'd0;
        bus.cmd_wb = 1'b0;
        bus.rsp_ready = 1'b1;
        for (int r = 0; r < 4; r++) rf_poke(2'(r), 4'h0);
        @(negedge clk);
        n_checks++;
        if (bus.cmd_ready !== 1'b1) begin n_fail++; $display("FAIL reset_cmd_ready got %b required 1", bus.cmd_ready); end
        n_checks++;
        if ({bus.rsp_valid, bus.rsp_data, bus.rsp_carry, bus.rsp_err, busy, rf_wr_en} !== 9'd0) begin
            n_fail++; $display("FAIL reset_outputs got valid=%b data=%h carry=%b err=%b busy=%b wr_en=%b required all 0",
                               bus.rsp_valid, bus.rsp_data, bus.rsp_carry, bus.rsp_err, busy, rf_wr_en);
        end
        n_checks++;
        if ({rf_rd_addr, alu_a, alu_b, alu_control, rf_wr_addr, rf_wr_data} !== 19'd0) begin
            n_fail++; $display("FAIL reset_ports got rd=%h a=%h b=%h ctl=%h wa=%h wd=%h required all 0",
                               rf_rd_addr, alu_a, alu_b, alu_control, rf_wr_addr, rf_wr_data);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({bus.cmd_ready, busy, bus.rsp_valid} !== 3'b100) begin
            n_fail++; $display("FAIL reset_release got ready=%b busy=%b valid=%b required 1 0 0",
                               bus.cmd_ready, busy, bus.rsp_valid);
        end
    endtask

    task automatic test_basic();
        int ro, re, wo, lat;
        ro = obs_rsp.size(); re = exp_rsp.size(); wo = obs_wr.size();
        push_cmd(3'b010, 2'd0, 2'd1, 4'd5, 1'b1, 1'b1);
        lat = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (bus.rsp_valid) break;
        end
        n_checks++;
        if (lat !== 4) begin n_fail++; $display("FAIL basic_latency got %0d required 4", lat); end
        n_checks++;
        if (bus.rsp_data !== 4'h5) begin n_fail++; $display("FAIL basic_rsp_data got %h required 5", bus.rsp_data); end
        drain();
        n_checks++;
        if (obs_wr.size() - wo !== 1) begin
            n_fail++; $display("FAIL basic_write_count got %0d required 1", obs_wr.size() - wo);
        end else begin
            n_checks++;
            if (obs_wr[wo] !== {2'd1, 4'h5}) begin
                n_fail++; $display("FAIL basic_write got addr=%h data=%h required addr=1 data=5", obs_wr[wo].addr, obs_wr[wo].data);
            end
        end
        n_checks++;
        if (obs_rsp.size() - ro !== exp_rsp.size() - re) begin
            n_fail++; $display("FAIL basic_rsp_count got %0d required %0d", obs_rsp.size() - ro, exp_rsp.size() - re);
        end else if (obs_rsp[ro] !== exp_rsp[re]) begin
            n_fail++; $display("FAIL basic_rsp got %h required %h", obs_rsp[ro], exp_rsp[re]);
        end
    endtask

    task automatic test_sub_slt();
        int ro, wo;
        rf_poke(2'd1, 4'd3);
        ro = obs_rsp.size(); wo = obs_wr.size();
        push_cmd(3'b110, 2'd1, 2'd2, 4'd5, 1'b1, 1'b1);
        push_cmd(3'b111, 2'd1, 2'd3, 4'd5, 1'b0, 1'b1);
        drain();
        n_checks++;
        if (obs_rsp.size() - ro !== 2) begin
            n_fail++; $display("FAIL subslt_rsp_count got %0d required 2", obs_rsp.size() - ro);
        end else begin
            n_checks++;
            if (obs_rsp[ro] !== {4'hE, 1'b0, 1'b0}) begin
                n_fail++; $display("FAIL sub_rsp got data=%h carry=%b err=%b required E 0 0",
                                   obs_rsp[ro].data, obs_rsp[ro].carry, obs_rsp[ro].err);
            end
            n_checks++;
            if (obs_rsp[ro+1] !== {4'h1, 1'b0, 1'b0}) begin
                n_fail++; $display("FAIL slt_rsp got data=%h carry=%b err=%b required 1 0 0",
                                   obs_rsp[ro+1].data, obs_rsp[ro+1].carry, obs_rsp[ro+1].err);
            end
        end
        n_checks++;
        if (obs_wr.size() - wo !== 1) begin
            n_fail++; $display("FAIL subslt_write_count got %0d required 1", obs_wr.size() - wo);
        end else begin
            n_checks++;
            if (obs_wr[wo] !== {2'd2, 4'hE}) begin
                n_fail++; $display("FAIL sub_write got addr=%h data=%h required 2 E", obs_wr[wo].addr, obs_wr[wo].data);
            end
        end
    endtask

    task automatic test_backpressure();
        int ro, re, wo, we;
        ro = obs_rsp.size(); re = exp_rsp.size(); wo = obs_wr.size(); we = exp_wr.size();
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        for (int i = 0; i < FIFO_DEPTH + 1; i++) push_random();
        repeat (6) @(negedge clk);
        n_checks++;
        if (bus.cmd_ready !== 1'b0) begin n_fail++; $display("FAIL bp_cmd_ready got %b required 0", bus.cmd_ready); end
        n_checks++;
        if (obs_rsp.size() !== ro || bus.rsp_valid !== 1'b1) begin
            n_fail++; $display("FAIL bp_stall got %0d responses valid=%b required 0 responses valid=1", obs_rsp.size() - ro, bus.rsp_valid);
        end
        bus.rsp_ready = 1'b1;
        push_random();
        drain();
        n_checks++;
        if (obs_rsp.size() - ro !== FIFO_DEPTH + 2 || exp_rsp.size() - re !== FIFO_DEPTH + 2) begin
            n_fail++; $display("FAIL bp_rsp_count got %0d required %0d", obs_rsp.size() - ro, FIFO_DEPTH + 2);
        end
        for (int i = 0; i < exp_rsp.size() - re && ro + i < obs_rsp.size(); i++) begin
            n_checks++;
            if (obs_rsp[ro+i] !== exp_rsp[re+i]) begin
                n_fail++; $display("FAIL bp_rsp[%0d] got %h required %h", i, obs_rsp[ro+i], exp_rsp[re+i]);
            end
        end
        n_checks++;
        if (obs_wr.size() - wo !== exp_wr.size() - we) begin
            n_fail++; $display("FAIL bp_write_count got %0d required %0d", obs_wr.size() - wo, exp_wr.size() - we);
        end else begin
            for (int i = 0; i < exp_wr.size() - we; i++) begin
                n_checks++;
                if (obs_wr[wo+i] !== exp_wr[we+i]) begin
                    n_fail++; $display("FAIL bp_write[%0d] got %h required %h", i, obs_wr[wo+i], exp_wr[we+i]);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        int ro, re;
        ro = obs_rsp.size(); re = exp_rsp.size();
        for (int i = 0; i < 6; i++) push_random();
        drain();
        n_checks++;
        if (obs_rsp.size() - ro !== 6) begin
            n_fail++; $display("FAIL b2b_rsp_count got %0d required 6", obs_rsp.size() - ro);
        end else begin
            for (int i = 0; i < 6; i++) begin
                n_checks++;
                if (obs_rsp[ro+i] !== exp_rsp[re+i]) begin
                    n_fail++; $display("FAIL b2b_rsp[%0d] got %h required %h", i, obs_rsp[ro+i], exp_rsp[re+i]);
                end
            end
            for (int i = 1; i < 6; i++) begin
                n_checks++;
                if (hs_cyc[ro+i] - hs_cyc[ro+i-1] !== 5) begin
                    n_fail++; $display("FAIL b2b_interval[%0d] got %0d required 5", i, hs_cyc[ro+i] - hs_cyc[ro+i-1]);
                end
            end
        end
    endtask

    task automatic test_illegal_op();
        int ro, wo;
        rf_poke(2'd2, 4'd6);
        ro = obs_rsp.size(); wo = obs_wr.size();
        push_cmd(3'b011, 2'd2, 2'd0, 4'd3, 1'b1, 1'b1);
        drain();
        n_checks++;
        if (obs_rsp.size() - ro !== 1) begin
            n_fail++; $display("FAIL illegal_rsp_count got %0d required 1", obs_rsp.size() - ro);
        end else begin
            n_checks++;
`ifdef CALC_SEQ_ERR_CHECK_EN
            if (obs_rsp[ro] !== {4'h0, 1'b0, 1'b1}) begin
                n_fail++; $display("FAIL illegal_rsp got data=%h carry=%b err=%b required 0 0 1",
                                   obs_rsp[ro].data, obs_rsp[ro].carry, obs_rsp[ro].err);
            end
`else
            if (obs_rsp[ro] !== {4'h5, 1'b0, 1'b0}) begin
                n_fail++; $display("FAIL illegal_rsp got data=%h carry=%b err=%b required 5 0 0",
                                   obs_rsp[ro].data, obs_rsp[ro].carry, obs_rsp[ro].err);
            end
`endif
        end
        n_checks++;
`ifdef CALC_SEQ_ERR_CHECK_EN
        if (obs_wr.size() - wo !== 0) begin
            n_fail++; $display("FAIL illegal_write_count got %0d required 0", obs_wr.size() - wo);
        end
`else
        if (obs_wr.size() - wo !== 1 || rf[0] !== 4'h5) begin
            n_fail++; $display("FAIL illegal_write got count=%0d r0=%h required count=1 r0=5", obs_wr.size() - wo, rf[0]);
        end
`endif
    endtask

    task automatic test_reset_write();
        int ro;
        bit seen;
        rf_poke(2'd3, 4'h0);
        ro = obs_rsp.size();
        seen = 0;
        push_cmd(3'b001, 2'd3, 2'd3, 4'hF, 1'b1, 1'b0);
        for (int i = 0; i < 30 && !seen; i++) begin
            @(negedge clk);
            if (rf_wr_en) seen = 1;
        end
        n_checks++;
        if (!seen) begin n_fail++; $display("FAIL rstwr_write_seen got 0 required 1"); end
        #1 rst_n = 1'b0;
        #1;
        n_checks++;
        if (rf_wr_en !== 1'b0) begin n_fail++; $display("FAIL rstwr_wr_en got %b required 0", rf_wr_en); end
        n_checks++;
        if ({busy, bus.cmd_ready, bus.rsp_valid} !== 3'b010) begin
            n_fail++; $display("FAIL rstwr_state got busy=%b ready=%b valid=%b required 0 1 0", busy, bus.cmd_ready, bus.rsp_valid);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        n_checks++;
        if (rf[3] !== 4'h0) begin n_fail++; $display("FAIL rstwr_no_commit got r3=%h required 0", rf[3]); end
        n_checks++;
        if (obs_rsp.size() !== ro || busy !== 1'b0) begin
            n_fail++; $display("FAIL rstwr_no_response got %0d responses busy=%b required 0 busy=0", obs_rsp.size() - ro, busy);
        end
    endtask

    task automatic test_random();
        int ro, re, wo, we;
        bit done;
        ro = obs_rsp.size(); re = exp_rsp.size(); wo = obs_wr.size(); we = exp_wr.size();
        done = 0;
        fork
            begin
                for (int i = 0; i < 24; i++) begin
                    repeat ($urandom_range(0, 3)) @(negedge clk);
                    push_random();
                end
                done = 1;
            end
            begin
                while (!done) begin
                    @(posedge clk);
                    #1 bus.rsp_ready = 1'($urandom_range(0, 1));
                end
                bus.rsp_ready = 1'b1;
            end
        join
        drain();
        n_checks++;
        if (obs_rsp.size() - ro !== exp_rsp.size() - re) begin
            n_fail++; $display("FAIL rand_rsp_count got %0d required %0d", obs_rsp.size() - ro, exp_rsp.size() - re);
        end
        for (int i = 0; i < exp_rsp.size() - re && ro + i < obs_rsp.size(); i++) begin
            n_checks++;
            if (obs_rsp[ro+i] !== exp_rsp[re+i]) begin
                n_fail++; $display("FAIL rand_rsp[%0d] got %h required %h", i, obs_rsp[ro+i], exp_rsp[re+i]);
            end
        end
        n_checks++;
        if (obs_wr.size() - wo !== exp_wr.size() - we) begin
            n_fail++; $display("FAIL rand_write_count got %0d required %0d", obs_wr.size() - wo, exp_wr.size() - we);
        end else begin
            for (int i = 0; i < exp_wr.size() - we; i++) begin
                n_checks++;
                if (obs_wr[wo+i] !== exp_wr[we+i]) begin
                    n_fail++; $display("FAIL rand_write[%0d] got %h required %h", i, obs_wr[wo+i], exp_wr[we+i]);
                end
            end
        end
        for (int r = 0; r < 4; r++) begin
            n_checks++;
            if (rf[r] !== mdl_rf[r]) begin
                n_fail++; $display("FAIL rand_rf[%0d] got %h required %h", r, rf[r], mdl_rf[r]);
            end
        end
    endtask

    task automatic test_protocol();
        n_checks++;
        if (viol !== 0) begin n_fail++; $display("FAIL protocol_violations got %0d required 0", viol); end
        n_checks++;
        if (push_timeouts !== 0) begin n_fail++; $display("FAIL push_timeouts got %0d required 0", push_timeouts); end
        n_checks++;
        if (drain_timeouts !== 0) begin n_fail++; $display("FAIL drain_timeouts got %0d required 0", drain_timeouts); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_sub_slt();
        test_backpressure();
        test_back_to_back();
        test_illegal_op();
        test_reset_write();
        test_random();
        test_protocol();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
